mips_multicycle_cpu: RTL and testbench
======================================

Name: mips_multicycle_cpu

Overview:
- Multicycle 32-bit MIPS-subset processor core with a von Neumann memory interface (one shared instruction/data bus).
- Sits between the system clock/reset and an external memory plus an I/O-mapped region.
- Address decode (RAM below 0x0000FF00, I/O at 0x0000FF00–0x0000FFFF) and read-data muxing are external; the core is address-agnostic.
- One instruction executes over 3–5 clock cycles, controlled by a central FSM.

Parameters:
- WIDTH, 32, datapath/register/address width in bits.
- REGBITS, 5, register-index width; register file holds 2^REGBITS registers.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- memdata  input  WIDTH  read data from memory/I/O; combinational w.r.t. adr; sampled on the rising edge that ends a read state.
- memread  output  1  high during instruction fetch and load-read states.
- memwrite  output  1  high for exactly one cycle per sw (store state).
- adr  output  WIDTH  byte address: PC during fetch; ALUOut (base+offset) during load/store.
- writedata  output  WIDTH  store data (rt register value); valid whenever memwrite=1.

Behaviour:
- Reset (async, active-high): FSM=FETCH, PC=0, IR=0, all register-file entries=0.
- Reset outputs: memread=1, memwrite=0, adr=0.
- Reset mid-instruction aborts the instruction immediately; no partial register or memory writes after reset asserts.
- Register file: 2^REGBITS x WIDTH, two combinational read ports, one write port written on the clock edge. Register 0 reads 0 always; writes to it are ignored.
- Internal registers: PC, IR, MDR, A, B, ALUOut.
- Supported instructions (standard MIPS32 encoding):
  - R-type (op 000000): funct add 100000, sub 100010, and 100100, or 100101, slt 100110/101010.
  - lw (100011), sw (101011), beq (000100), addi (001000), j (000010).
- Arithmetic: WIDTH-bit two's complement, wrap on overflow, no exception. slt is signed; result is 1 or 0.
- Immediates are sign-extended to WIDTH. The core enforces no address alignment; e.g. sw with base 0, imm 5 drives adr=5.
- FSM states and transitions:
  - FETCH: memread=1, adr=PC. IR<=memdata; PC<=PC+4. -> DECODE.
  - DECODE: A<=rs, B<=rt; ALUOut<=PC+(signext(imm)<<2) as branch target. Next state by opcode: lw/sw -> MEMADR; R -> RTYPEEX; beq -> BEQEX; j -> JEX; addi -> ADDIEX; any other opcode -> FETCH (executes as NOP).
  - MEMADR: ALUOut<=A+signext(imm). lw -> LWRD; sw -> SWWR.
  - LWRD: memread=1, adr=ALUOut; MDR<=memdata. -> LWWR.
  - LWWR: rt<=MDR. -> FETCH.
  - SWWR: memwrite=1, adr=ALUOut, writedata=B. -> FETCH.
  - RTYPEEX: ALUOut<=A op B. -> RTYPEWR.
  - RTYPEWR: rd<=ALUOut. -> FETCH. An unknown funct writes 0.
  - ADDIEX: ALUOut<=A+signext(imm). -> ADDIWR.
  - ADDIWR: rt<=ALUOut. -> FETCH.
  - BEQEX: if A==B then PC<=ALUOut. -> FETCH.
  - JEX: PC<={PC[31:28], IR[25:0], 2'b00}. -> FETCH.
- Cycle counts: lw 5; sw, R-type, addi 4; beq, j 3.
- memread and memwrite are never high in the same cycle.
- In states that neither read nor write memory: memread=0 and memwrite=0; adr is don't-care.
- PC wraps modulo 2^WIDTH.

Test Plan:
- Reset: assert reset for 22 ns with a 10 ns clock. Required: memread=1, memwrite=0, adr=0 during reset; first fetch from adr 0 after release.
- Program `addi $2,$0,5; addi $3,$0,2; add $7,$2,$3; sw $7,5($0)` -> exactly one memwrite with adr=5, writedata=7; no earlier memwrite.
- Load and cycle count: `lw $4,8($0)` with memory word 0x1234 at address 8 -> memread with adr=8 in the LWRD cycle; $4=0x1234 (check via a later sw). Instruction takes 5 cycles.
- beq: taken branch with offset 2 at PC=0x10 -> next fetch adr=0x1C. Not-taken -> next fetch adr=0x14. `j 0x10` -> next fetch adr=0x40.
- R-type edge cases: sub 3−5 -> 0xFFFFFFFE; slt(−1,1) -> 1; `addi $0,$0,9` then `sw $0,0($0)` -> writedata=0.
- Reset asserted during the SWWR cycle (async) -> memwrite drops immediately; FSM restarts at FETCH with adr=0.

Source files
------------

// File: rtl/mips_multicycle_cpu.sv
// Multicycle 32-bit MIPS-subset core with a single shared instruction/data bus.
// Each instruction walks a central FSM: FETCH, DECODE, then 1-3 execute/memory/
// writeback states, so an instruction takes 3 to 5 cycles.
//
// Ports:
//   clk       - system clock, all state changes on the rising edge
//   reset     - asynchronous, active-high; aborts any instruction in flight
//   memdata   - read data from memory/I/O (combinational on adr)
//   memread   - high in FETCH and LWRD
//   memwrite  - high for the single SWWR cycle of a sw
//   adr       - byte address: PC in FETCH, ALUOut in LWRD/SWWR
//   writedata - store data (B register), valid while memwrite is high
module mips_multicycle_cpu #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] memdata,
    output logic             memread,
    output logic             memwrite,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, LWRD, LWWR, SWWR,
        RTYPEEX, RTYPEWR, ADDIEX, ADDIWR, BEQEX, JEX
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] pc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
    logic [WIDTH-1:0] regs_q [2**REGBITS];

    // Instruction fields
    logic [5:0]         opcode, funct;
    logic [REGBITS-1:0] rs_idx, rt_idx, rd_idx;
    logic [WIDTH-1:0]   imm_ext, rs_data, rt_data, alu_r;
    logic               unused_shamt;

    assign opcode       = ir_q[31:26];
    assign funct        = ir_q[5:0];
    assign rs_idx       = ir_q[21 +: REGBITS];
    assign rt_idx       = ir_q[16 +: REGBITS];
    assign rd_idx       = ir_q[11 +: REGBITS];
    assign imm_ext      = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
    assign unused_shamt = ^ir_q[10:6];

    // Register 0 is hard-wired to zero on the read side as well as the write side.
    assign rs_data   = (rs_idx == '0) ? '0 : regs_q[rs_idx];
    assign rt_data   = (rt_idx == '0) ? '0 : regs_q[rt_idx];
    assign writedata = b_q;

    // R-type ALU; both 100110 and 101010 decode as signed set-less-than.
    always_comb begin
        alu_r = '0;
        case (funct)
            6'b100000: alu_r = a_q + b_q;
            6'b100010: alu_r = a_q - b_q;
            6'b100100: alu_r = a_q & b_q;
            6'b100101: alu_r = a_q | b_q;
            6'b100110,
            6'b101010: alu_r = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            default:   alu_r = '0;
        endcase
    end

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = FETCH;    // unknown opcode: NOP
                endcase
            end
            MEMADR:  state_d = (opcode == OP_LW) ? LWRD : SWWR;
            LWRD:    state_d = LWWR;
            RTYPEEX: state_d = RTYPEWR;
            ADDIEX:  state_d = ADDIWR;
            default: state_d = FETCH;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    logic               rf_we;
    logic [REGBITS-1:0] rf_waddr;
    logic [WIDTH-1:0]   rf_wdata;

    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        adr      = pc_q;
        rf_we    = 1'b0;
        rf_waddr = rt_idx;
        rf_wdata = aluout_q;
        case (state_q)
            FETCH:   memread = 1'b1;
            LWRD:    begin memread  = 1'b1; adr = aluout_q; end
            SWWR:    begin memwrite = 1'b1; adr = aluout_q; end
            LWWR:    begin rf_we = 1'b1; rf_wdata = mdr_q; end
            ADDIWR:  rf_we = 1'b1;
            RTYPEWR: begin rf_we = 1'b1; rf_waddr = rd_idx; end
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    ir_q <= memdata;
                    pc_q <= pc_q + WIDTH'(4);
                end
                DECODE: begin
                    a_q      <= rs_data;
                    b_q      <= rt_data;
                    aluout_q <= pc_q + (imm_ext << 2);   // branch target
                end
                MEMADR, ADDIEX: aluout_q <= a_q + imm_ext;
                LWRD:           mdr_q    <= memdata;
                RTYPEEX:        aluout_q <= alu_r;
                BEQEX:          if (a_q == b_q) pc_q <= aluout_q;
                JEX:            pc_q <= {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    // ---------------- Register file ----------------
    // NOTE: the register file array is reset explicitly because software relies
    // on every register reading zero after reset; it cannot be left uninitialised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**REGBITS; i++) regs_q[i] <= '0;
        end else if (rf_we && rf_waddr != '0) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Directed bench for mips_multicycle_cpu: small hand-assembled programs in a
// word-addressed memory model, expected bus activity computed by hand.
module tb_mips_multicycle_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memdata;
    logic        memread, memwrite;
    logic [31:0] adr, writedata;

    logic [31:0] mem [64];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int overlap  = 0;

    localparam logic [31:0] NOP_WORD = 32'hFC00_0000;   // opcode 111111

    always #5 clk = ~clk;

    assign memdata = (adr < 32'd256) ? mem[adr[7:2]] : NOP_WORD;

    mips_multicycle_cpu dut (
        .clk       (clk),
        .reset     (reset),
        .memdata   (memdata),
        .memread   (memread),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata)
    );

    always @(negedge clk) if (memread && memwrite) overlap++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [5:0] f);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'b000010, target};
    endfunction

    localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = NOP_WORD;
    endtask

    // Advance one clock, sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic advance_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        cyc = 0;
    endtask

    // Run to the next memwrite cycle (bounded), check it, then step past it.
    task automatic expect_store(input string tag, input logic [31:0] exp_adr,
                                input logic [31:0] exp_data, input int exp_cyc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (memwrite) found = 1'b1;
            else          step();
        end
        check({tag, "_seen"}, {31'b0, found}, 32'd1);
        if (found) begin
            check({tag, "_adr"}, adr, exp_adr);
            check({tag, "_data"}, writedata, exp_data);
            if (exp_cyc >= 0) check({tag, "_cycle"}, cyc, exp_cyc);
            step();
        end
    endtask

    initial begin
        // ---------------- Phase A: reset, store, branches, ALU ----------------
        clear_mem();
        mem[0]  = enc_i(ADDI, 0, 2, 16'd5);           // addi $2,$0,5
        mem[1]  = enc_i(ADDI, 0, 3, 16'd2);           // addi $3,$0,2
        mem[2]  = enc_r(2, 3, 7, 6'b100000);          // add  $7,$2,$3
        mem[3]  = enc_i(SW, 0, 7, 16'd5);             // sw   $7,5($0)
        mem[4]  = enc_i(BEQ, 2, 2, 16'd2);            // 0x10: beq taken -> 0x1C
        mem[7]  = enc_i(BEQ, 2, 3, 16'd5);            // 0x1C: beq not taken -> 0x20
        mem[8]  = enc_j(26'h10);                      // 0x20: j 0x10 -> 0x40
        mem[16] = enc_i(ADDI, 0, 9, 16'd3);           // addi $9,$0,3
        mem[17] = enc_r(9, 2, 8, 6'b100010);          // sub  $8,$9,$2 = -2
        mem[18] = enc_i(SW, 0, 8, 16'd0);
        mem[19] = enc_i(ADDI, 0, 10, 16'hFFFF);       // $10 = -1
        mem[20] = enc_i(ADDI, 0, 11, 16'd1);          // $11 = 1
        mem[21] = enc_r(10, 11, 12, 6'b101010);       // slt -1<1 = 1
        mem[22] = enc_i(SW, 0, 12, 16'd4);
        mem[23] = enc_r(10, 11, 13, 6'b100110);       // slt (alt funct) = 1
        mem[24] = enc_i(SW, 0, 13, 16'd8);
        mem[25] = enc_r(2, 3, 14, 6'b100101);         // or  5|2 = 7
        mem[26] = enc_r(14, 2, 15, 6'b100100);        // and 7&5 = 5
        mem[27] = enc_i(SW, 0, 14, 16'd12);
        mem[28] = enc_i(SW, 0, 15, 16'd16);
        mem[29] = enc_i(ADDI, 0, 0, 16'd9);           // addi $0,$0,9 (ignored)
        mem[30] = enc_i(SW, 0, 0, 16'd0);
        mem[31] = NOP_WORD;                           // unknown opcode
        mem[32] = enc_i(SW, 0, 2, 16'd24);            // $2 still 5
        mem[33] = enc_r(9, 9, 2, 6'b000000);          // unknown funct -> $2 = 0
        mem[34] = enc_i(SW, 0, 2, 16'd28);

        reset = 1'b1;
        #3;
        check("rst_memread",  {31'b0, memread},  32'd1);
        check("rst_memwrite", {31'b0, memwrite}, 32'd0);
        check("rst_adr",      adr,               32'd0);
        #14;                                           // t=17, after two edges in reset
        check("rst_hold_adr", adr, 32'd0);
        #5;                                            // t=22
        reset = 1'b0;
        #1;
        cyc = 0;
        check("first_fetch_memread", {31'b0, memread}, 32'd1);
        check("first_fetch_adr",     adr,               32'd0);

        expect_store("sw7", 32'd5, 32'd7, 15);
        check("fetch_beq_adr", adr, 32'h10);
        advance_to(19);
        check("beq_taken_adr",  adr, 32'h1C);
        check("beq_taken_rd",   {31'b0, memread}, 32'd1);
        advance_to(22);
        check("beq_nt_adr",     adr, 32'h20);
        advance_to(25);
        check("jump_adr",       adr, 32'h40);

        expect_store("sub",    32'd0,  32'hFFFF_FFFE, -1);
        expect_store("slt",    32'd4,  32'd1, -1);
        expect_store("slt_alt",32'd8,  32'd1, -1);
        expect_store("or",     32'd12, 32'd7, -1);
        expect_store("and",    32'd16, 32'd5, -1);
        expect_store("r0",     32'd0,  32'd0, -1);
        expect_store("nop_op", 32'd24, 32'd5, -1);
        expect_store("bad_fn", 32'd28, 32'd0, -1);

        // ---------------- Phase B: load timing and register reset ----------------
        clear_mem();
        mem[0] = enc_i(LW, 0, 4, 16'd8);              // lw $4,8($0)
        mem[1] = enc_j(26'h4);                        // j 0x10
        mem[2] = 32'h0000_1234;                       // data word at 8
        mem[4] = enc_i(SW, 0, 4, 16'h10);             // sw $4,0x10($0)
        mem[5] = enc_i(SW, 0, 7, 16'h14);             // $7 cleared by reset
        do_reset();
        advance_to(3);
        check("lwrd_memread", {31'b0, memread}, 32'd1);
        check("lwrd_adr",     adr,               32'd8);
        advance_to(5);
        check("lw_5cyc_adr",  adr,               32'd4);
        check("lw_5cyc_rd",   {31'b0, memread}, 32'd1);
        expect_store("lw_val", 32'h10, 32'h0000_1234, 11);
        expect_store("rf_rst", 32'h14, 32'd0, 15);

        // ---------------- Phase C: reset during SWWR ----------------
        clear_mem();
        mem[0] = enc_i(ADDI, 0, 5, 16'h77);
        mem[1] = enc_i(SW, 0, 5, 16'h20);
        do_reset();
        begin : abort_store
            logic found;
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                if (memwrite) found = 1'b1;
                else          step();
            end
            check("swwr_reached", {31'b0, found}, 32'd1);
            check("swwr_cycle",   cyc,            32'd7);
        end
        #2;
        reset = 1'b1;
        #1;
        check("abort_memwrite", {31'b0, memwrite}, 32'd0);
        check("abort_memread",  {31'b0, memread},  32'd1);
        check("abort_adr",      adr,               32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("restart_decode_rd", {31'b0, memread}, 32'd0);

        check("rw_exclusive", overlap, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
